id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register of the RV32I core. It sits directly downstream of the register file and decoder.
//  It captures RD1/RD2, immediate, PC and control for the execute stage.
//  It detects load-use hazards: stalls IF/ID and inserts a bubble. It also squashes the decoded instruction on a taken branch/jump (ex_flush).

---
 rtl/id_ex_pipe_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion and flush squash.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              ex_flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_fd,
    output logic              flush_d,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    logic              ex_valid_r;
    logic [XLEN-1:0]   ex_pc_r;
    logic [XLEN-1:0]   ex_rd1_r;
    logic [XLEN-1:0]   ex_rd2_r;
    logic [XLEN-1:0]   ex_imm_r;
    logic [4:0]        ex_rs1_r;
    logic [4:0]        ex_rs2_r;
    logic [4:0]        ex_rd_r;
    logic [CTRL_W-1:0] ex_ctrl_r;

    logic rs1_hit_s;
    logic rs2_hit_s;
    logic lu_haz_s;
    logic bubble_s;
    logic stall_fd_s;
    logic flush_d_s;

    // Load-use detection against the load currently sitting in EX (ctrl bit1 = mem_read).
    always_comb begin
        rs1_hit_s  = id_use_rs1 && (id_rs1 == ex_rd_r);
        rs2_hit_s  = id_use_rs2 && (id_rs2 == ex_rd_r);
        lu_haz_s   = id_valid && ex_valid_r && ex_ctrl_r[1] && (ex_rd_r != 5'd0)
                     && (rs1_hit_s || rs2_hit_s);
        stall_fd_s = lu_haz_s && !ex_flush && !hold;
        flush_d_s  = ex_flush && !hold;
        bubble_s   = ex_flush || lu_haz_s;
    end

    assign stall_fd = stall_fd_s;
    assign flush_d  = flush_d_s;

    // Pipeline register: hold > bubble (flush or load-use) > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_pc_r    <= {XLEN{1'b0}};
            ex_rd1_r   <= {XLEN{1'b0}};
            ex_rd2_r   <= {XLEN{1'b0}};
            ex_imm_r   <= {XLEN{1'b0}};
            ex_rs1_r   <= 5'd0;
            ex_rs2_r   <= 5'd0;
            ex_rd_r    <= 5'd0;
            ex_ctrl_r  <= {CTRL_W{1'b0}};
        end else if (!hold) begin
            if (bubble_s) begin
                ex_valid_r <= 1'b0;
                ex_pc_r    <= {XLEN{1'b0}};
                ex_rd1_r   <= {XLEN{1'b0}};
                ex_rd2_r   <= {XLEN{1'b0}};
                ex_imm_r   <= {XLEN{1'b0}};
                ex_rs1_r   <= 5'd0;
                ex_rs2_r   <= 5'd0;
                ex_rd_r    <= 5'd0;
                ex_ctrl_r  <= {CTRL_W{1'b0}};
            end else begin
                ex_valid_r <= id_valid;
                ex_pc_r    <= id_pc;
                ex_rd1_r   <= id_rd1;
                ex_rd2_r   <= id_rd2;
                ex_imm_r   <= id_imm;
                ex_rs1_r   <= id_rs1;
                ex_rs2_r   <= id_rs2;
                ex_rd_r    <= id_rd;
                // An empty decode slot must not carry side effects into EX.
                ex_ctrl_r  <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
            end
        end
    end

    assign ex_valid = ex_valid_r;
    assign ex_pc    = ex_pc_r;
    assign ex_rd1   = ex_rd1_r;
    assign ex_rd2   = ex_rd2_r;
    assign ex_imm   = ex_imm_r;
    assign ex_rs1   = ex_rs1_r;
    assign ex_rs2   = ex_rs2_r;
    assign ex_rd    = ex_rd_r;
    assign ex_ctrl  = ex_ctrl_r;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Event counters, free-running and wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_fd_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (flush_d_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Table-driven bench for id_ex_pipe_reg plus hand sequences for async reset and post-reset flush.
module tb_id_ex_pipe_reg;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [31:0] PERF = 32'd1;
`else
    localparam logic [31:0] PERF = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, hold, ex_flush, id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [7:0]  id_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic        stall_fd, flush_d;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .ex_flush(ex_flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .stall_fd(stall_fd), .flush_d(flush_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic        hold, flush, vld;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [7:0]  ctrl;
        logic        e_stall, e_fd, e_vld;
        logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [7:0]  e_ctrl;
        logic [31:0] e_sc, e_fc;
    } vec_t;

    vec_t tbl [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_pc"}, ex_pc, 32'd0);
        chk({tag, "_rd1"}, ex_rd1, 32'd0);
        chk({tag, "_rd2"}, ex_rd2, 32'd0);
        chk({tag, "_imm"}, ex_imm, 32'd0);
        chk({tag, "_regs"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
        chk({tag, "_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_fd}, 32'd0);
        chk({tag, "_scnt"}, stall_cnt, 32'd0);
        chk({tag, "_fcnt"}, flush_cnt, 32'd0);
    endtask

    task automatic drive(input vec_t v);
        hold = v.hold; ex_flush = v.flush; id_valid = v.vld;
        id_pc = v.pc; id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_ctrl = v.ctrl;
    endtask

    initial begin
        // capture, load-use, x0 / unused-source filters, flush vs hazard, hold, invalid slot
        tbl[0]  = '{1'b0,1'b0,1'b1, 32'h100,32'hA5A5A5A5,32'h11,32'hFFFFFFFC, 5'd1,5'd2,5'd5, 1'b1,1'b1, 8'h01,
                    1'b0,1'b0,1'b1, 32'h100,32'hA5A5A5A5,32'h11,32'hFFFFFFFC, 5'd1,5'd2,5'd5, 8'h01, 32'd0,32'd0};
        tbl[1]  = '{1'b0,1'b0,1'b1, 32'h104,32'h1000,32'h0,32'h8, 5'd2,5'd0,5'd7, 1'b1,1'b0, 8'h03,
                    1'b0,1'b0,1'b1, 32'h104,32'h1000,32'h0,32'h8, 5'd2,5'd0,5'd7, 8'h03, 32'd0,32'd0};
        tbl[2]  = '{1'b0,1'b0,1'b1, 32'h108,32'h22,32'h33,32'h0, 5'd1,5'd7,5'd9, 1'b1,1'b1, 8'h01,
                    1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, 5'd0,5'd0,5'd0, 8'h00, 32'd1,32'd0};
        tbl[3]  = '{1'b0,1'b0,1'b1, 32'h108,32'h22,32'h33,32'h0, 5'd1,5'd7,5'd9, 1'b1,1'b1, 8'h01,
                    1'b0,1'b0,1'b1, 32'h108,32'h22,32'h33,32'h0, 5'd1,5'd7,5'd9, 8'h01, 32'd1,32'd0};
        tbl[4]  = '{1'b0,1'b0,1'b1, 32'h10C,32'h40,32'h0,32'h4, 5'd5,5'd0,5'd0, 1'b1,1'b0, 8'h03,
                    1'b0,1'b0,1'b1, 32'h10C,32'h40,32'h0,32'h4, 5'd5,5'd0,5'd0, 8'h03, 32'd1,32'd0};
        tbl[5]  = '{1'b0,1'b0,1'b1, 32'h110,32'h0,32'h0,32'h10, 5'd0,5'd6,5'd8, 1'b1,1'b1, 8'h01,
                    1'b0,1'b0,1'b1, 32'h110,32'h0,32'h0,32'h10, 5'd0,5'd6,5'd8, 8'h01, 32'd1,32'd0};
        tbl[6]  = '{1'b0,1'b0,1'b1, 32'h114,32'h50,32'h0,32'h0, 5'd8,5'd0,5'd3, 1'b1,1'b0, 8'h03,
                    1'b0,1'b0,1'b1, 32'h114,32'h50,32'h0,32'h0, 5'd8,5'd0,5'd3, 8'h03, 32'd1,32'd0};
        tbl[7]  = '{1'b0,1'b0,1'b1, 32'h118,32'h60,32'h3,32'h20, 5'd4,5'd3,5'd10, 1'b1,1'b0, 8'h05,
                    1'b0,1'b0,1'b1, 32'h118,32'h60,32'h3,32'h20, 5'd4,5'd3,5'd10, 8'h05, 32'd1,32'd0};
        tbl[8]  = '{1'b0,1'b0,1'b1, 32'h11C,32'h70,32'h0,32'hC, 5'd1,5'd0,5'd12, 1'b1,1'b0, 8'h03,
                    1'b0,1'b0,1'b1, 32'h11C,32'h70,32'h0,32'hC, 5'd1,5'd0,5'd12, 8'h03, 32'd1,32'd0};
        tbl[9]  = '{1'b0,1'b1,1'b1, 32'h120,32'h80,32'h0,32'h0, 5'd12,5'd0,5'd13, 1'b1,1'b0, 8'h01,
                    1'b0,1'b1,1'b0, 32'h0,32'h0,32'h0,32'h0, 5'd0,5'd0,5'd0, 8'h00, 32'd1,32'd1};
        tbl[10] = '{1'b0,1'b0,1'b1, 32'h124,32'h90,32'h91,32'h30, 5'd2,5'd3,5'd14, 1'b1,1'b1, 8'h81,
                    1'b0,1'b0,1'b1, 32'h124,32'h90,32'h91,32'h30, 5'd2,5'd3,5'd14, 8'h81, 32'd1,32'd1};
        tbl[11] = '{1'b1,1'b1,1'b1, 32'h200,32'hAA,32'hAB,32'h40, 5'd14,5'd14,5'd1, 1'b1,1'b1, 8'h03,
                    1'b0,1'b0,1'b1, 32'h124,32'h90,32'h91,32'h30, 5'd2,5'd3,5'd14, 8'h81, 32'd1,32'd1};
        tbl[12] = '{1'b1,1'b1,1'b0, 32'h204,32'hBB,32'hBC,32'h44, 5'd3,5'd4,5'd5, 1'b0,1'b0, 8'h00,
                    1'b0,1'b0,1'b1, 32'h124,32'h90,32'h91,32'h30, 5'd2,5'd3,5'd14, 8'h81, 32'd1,32'd1};
        tbl[13] = '{1'b1,1'b1,1'b1, 32'h208,32'hCC,32'hCD,32'h48, 5'd6,5'd7,5'd8, 1'b1,1'b1, 8'hFF,
                    1'b0,1'b0,1'b1, 32'h124,32'h90,32'h91,32'h30, 5'd2,5'd3,5'd14, 8'h81, 32'd1,32'd1};
        tbl[14] = '{1'b0,1'b0,1'b0, 32'h300,32'hDEAD,32'hBEEF,32'h1, 5'd1,5'd2,5'd15, 1'b1,1'b1, 8'h07,
                    1'b0,1'b0,1'b0, 32'h300,32'hDEAD,32'hBEEF,32'h1, 5'd1,5'd2,5'd15, 8'h00, 32'd1,32'd1};
        tbl[15] = '{1'b0,1'b0,1'b1, 32'h304,32'h0,32'h0,32'h0, 5'd1,5'd0,5'd6, 1'b1,1'b0, 8'h03,
                    1'b0,1'b0,1'b1, 32'h304,32'h0,32'h0,32'h0, 5'd1,5'd0,5'd6, 8'h03, 32'd1,32'd1};

        rst_n = 1'b0;
        drive('{default: '0});
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("r%0d_stall_fd", i), {31'd0, stall_fd}, {31'd0, tbl[i].e_stall});
            chk($sformatf("r%0d_flush_d", i), {31'd0, flush_d}, {31'd0, tbl[i].e_fd});
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("r%0d_pc", i), ex_pc, tbl[i].e_pc);
            chk($sformatf("r%0d_rd1", i), ex_rd1, tbl[i].e_rd1);
            chk($sformatf("r%0d_rd2", i), ex_rd2, tbl[i].e_rd2);
            chk($sformatf("r%0d_imm", i), ex_imm, tbl[i].e_imm);
            chk($sformatf("r%0d_regs", i), {17'd0, ex_rs1, ex_rs2, ex_rd},
                {17'd0, tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_rd});
            chk($sformatf("r%0d_ctrl", i), {24'd0, ex_ctrl}, {24'd0, tbl[i].e_ctrl});
            chk($sformatf("r%0d_scnt", i), stall_cnt, tbl[i].e_sc * PERF);
            chk($sformatf("r%0d_fcnt", i), flush_cnt, tbl[i].e_fc * PERF);
            @(negedge clk);
        end

        // Async reset in the middle of a load-use stall (EX holds lw rd=6).
        id_valid = 1'b1; id_pc = 32'h308; id_rs1 = 5'd6; id_use_rs1 = 1'b1;
        id_rs2 = 5'd0; id_use_rs2 = 1'b0; id_rd = 5'd11; id_ctrl = 8'h01;
        id_rd1 = 32'h5; id_rd2 = 32'h6; id_imm = 32'h7;
        #1 chk("ar_stall_before", {31'd0, stall_fd}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_recover_valid", {31'd0, ex_valid}, 32'd1);
        chk("ar_recover_pc", ex_pc, 32'h308);
        chk("ar_recover_ctrl", {24'd0, ex_ctrl}, 32'h01);
        chk("ar_recover_scnt", stall_cnt, 32'd0);

        // One flush after reset: single bubble, counter restarts from zero.
        @(negedge clk);
        ex_flush = 1'b1;
        #1 chk("pf_flush_d", {31'd0, flush_d}, 32'd1);
        @(posedge clk);
        #1;
        chk("pf_valid", {31'd0, ex_valid}, 32'd0);
        chk("pf_fcnt", flush_cnt, PERF);
        @(negedge clk);
        ex_flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
